// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - FIFO read-side consumer presenting memory data as a valid/ready stream
//
// Drives the FIFO read enable, absorbs the memory's one-cycle registered read
// latency and buffers words in a 2-entry skid so the stream sustains one beat
// per cycle. Optional packet framing is enabled by defining FIFO_RD_LAST_EN.
//
// Ports:
//   r_clk          read-domain clock, all state on posedge
//   rreset         synchronous active-high reset (wins over flush)
//   flush          synchronous clear of the read path (xfer_cnt survives)
//   fifo_empty     FIFO empty flag
//   fifo_rd_enable read request; FIFO read pointer advances when high
//   fifo_rdata     registered read data, valid the cycle after fifo_rd_enable
//   m_valid        stream data valid
//   m_ready        downstream ready
//   m_data         stream data (head of buffer)
//   m_last         end of packet every PKT_BEATS beats (FIFO_RD_LAST_EN only)
//   xfer_cnt       completed stream beats, wraps modulo 2^CNT_WIDTH
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16,
  parameter int PKT_BEATS  = 4
) (
  input  logic                  r_clk,
  input  logic                  rreset,
  input  logic                  flush,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_enable,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
`ifdef FIFO_RD_LAST_EN
  output logic                  m_last,
`endif
  output logic [CNT_WIDTH-1:0]  xfer_cnt
);

  logic [1:0]            count_q, count_d;
  logic                  inflight_q;
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] mem_q [2];
  logic [CNT_WIDTH-1:0]  xfer_cnt_q, xfer_cnt_d;
  logic                  pop;
  logic [2:0]            occupancy;

  assign pop       = m_valid & m_ready;
  assign occupancy = {1'b0, count_q} + {2'b00, inflight_q};

  // A pop in this cycle frees a slot by the time the read data lands, so the
  // fetch budget grows by one; this keeps one beat per cycle under full flow.
  assign fifo_rd_enable = !rreset && !flush && !fifo_empty &&
                          (occupancy < (3'd2 + {2'b00, pop}));

  assign m_valid  = (count_q != 2'd0);
  assign m_data   = mem_q[rd_ptr_q];
  assign xfer_cnt = xfer_cnt_q;

  always_comb begin
    count_d    = count_q + {1'b0, inflight_q} - {1'b0, pop};
    wr_ptr_d   = inflight_q ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d   = pop ? ~rd_ptr_q : rd_ptr_q;
    xfer_cnt_d = pop ? xfer_cnt_q + CNT_WIDTH'(1) : xfer_cnt_q;
    if (flush) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end
  end

  always_ff @(posedge r_clk) begin
    if (rreset) begin
      count_q    <= 2'd0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      xfer_cnt_q <= '0;
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
    end else begin
      count_q    <= count_d;
      inflight_q <= fifo_rd_enable;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      xfer_cnt_q <= xfer_cnt_d;
      // A word landing during flush belongs to the discarded stream.
      if (inflight_q && !flush) mem_q[wr_ptr_q] <= fifo_rdata;
    end
  end

`ifdef FIFO_RD_LAST_EN
  localparam int BEAT_W = (PKT_BEATS > 1) ? $clog2(PKT_BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_BEATS - 1);

  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;

  assign m_last = m_valid && (beat_cnt_q == LAST_BEAT);

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (pop) beat_cnt_d = m_last ? '0 : beat_cnt_q + BEAT_W'(1);
    if (flush) beat_cnt_d = '0;
  end

  always_ff @(posedge r_clk) begin
    if (rreset) beat_cnt_q <= '0;
    else        beat_cnt_q <= beat_cnt_d;
  end
`endif

  a_no_overflow: assert property (@(posedge r_clk) disable iff (rreset) occupancy <= 3'd2);
  a_pkt_beats:   assert property (@(posedge r_clk) PKT_BEATS >= 1);

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb/tb_fifo_rd_stream.sv - self-checking bench for fifo_rd_stream
module tb_fifo_rd_stream;
  localparam int DW = 8;
  localparam int CW = 16;
  typedef logic [DW-1:0] word_t;

  logic          r_clk = 1'b0;
  logic          rreset = 1'b1;
  logic          flush = 1'b0;
  logic          fifo_empty = 1'b1;
  logic          fifo_rd_enable;
  word_t         fifo_rdata = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  word_t         m_data;
  logic [CW-1:0] xfer_cnt;
`ifdef FIFO_RD_LAST_EN
  logic          m_last;
`endif

  fifo_rd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .PKT_BEATS(4)) dut (
    .r_clk(r_clk), .rreset(rreset), .flush(flush), .fifo_empty(fifo_empty),
    .fifo_rd_enable(fifo_rd_enable), .fifo_rdata(fifo_rdata),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
`ifdef FIFO_RD_LAST_EN
    .m_last(m_last),
`endif
    .xfer_cnt(xfer_cnt)
  );

  always #5 r_clk = ~r_clk;

  int    n_tests = 0;
  int    n_fail = 0;
  word_t mem_q[$];      // words still held by the FIFO memory
  word_t pending_q[$];  // words read from the FIFO but not yet delivered
  word_t words_q[$];    // every word written in the current test
  word_t got_q[$];      // words observed on stream handshakes
  word_t exp_q[$];      // words the model says should have been delivered
  logic  got_last_q[$];
  int    model_xfer;
  logic  s_rd, s_valid, s_empty;
  word_t s_data;

  // One clock of environment: FIFO memory model plus stream observation.
  task automatic cycle();
    word_t rd_word;
    logic  do_pop, do_clr;
    rd_word = '0;
    @(negedge r_clk);
    s_rd    = fifo_rd_enable;
    s_valid = m_valid;
    s_data  = m_data;
    s_empty = fifo_empty;
    do_pop  = m_valid & m_ready & !rreset;
    do_clr  = flush | rreset;
    if (do_pop) begin
      got_q.push_back(m_data);
`ifdef FIFO_RD_LAST_EN
      got_last_q.push_back(m_last);
`endif
      if (pending_q.size() > 0) exp_q.push_back(pending_q.pop_front());
      else exp_q.push_back(~m_data);
      model_xfer++;
    end
    if (s_rd) begin
      if (mem_q.size() > 0) rd_word = mem_q.pop_front();
      pending_q.push_back(rd_word);
    end
    if (do_clr) pending_q.delete();
    if (rreset) model_xfer = 0;
    @(posedge r_clk);
    #1;
    if (s_rd) fifo_rdata = rd_word;
    if (do_clr) fifo_rdata = '0;
    fifo_empty = (mem_q.size() == 0);
  endtask

  task automatic push_word(input word_t w);
    mem_q.push_back(w);
    words_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic clear_logs();
    words_q.delete(); got_q.delete(); exp_q.delete(); got_last_q.delete();
  endtask

  task automatic do_reset();
    rreset = 1'b1; flush = 1'b0; m_ready = 1'b0;
    mem_q.delete(); fifo_empty = 1'b1;
    cycle(); cycle();
    rreset = 1'b0;
    clear_logs();
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cycle();
      n_tests++; if (s_rd !== 1'b0) begin n_fail++; $display("FAIL reset_rd cyc%0d: got %b expected 0", i, s_rd); end
      n_tests++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid cyc%0d: got %b expected 0", i, s_valid); end
      n_tests++; if (s_data !== 8'h00) begin n_fail++; $display("FAIL reset_data cyc%0d: got %h expected 00", i, s_data); end
      n_tests++; if (xfer_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_xfer cyc%0d: got %0d expected 0", i, xfer_cnt); end
    end
  endtask

  task automatic test_latency();
    logic  exp_rd[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic  exp_v[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    word_t exp_d[6]  = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
    do_reset();
    push_word(8'h11); push_word(8'h22); push_word(8'h33);
    m_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      n_tests++; if (s_rd !== exp_rd[i]) begin n_fail++; $display("FAIL lat_rd cyc%0d: got %b expected %b", i, s_rd, exp_rd[i]); end
      n_tests++; if (s_valid !== exp_v[i]) begin n_fail++; $display("FAIL lat_valid cyc%0d: got %b expected %b", i, s_valid, exp_v[i]); end
      if (exp_v[i]) begin
        n_tests++; if (s_data !== exp_d[i]) begin n_fail++; $display("FAIL lat_data cyc%0d: got %h expected %h", i, s_data, exp_d[i]); end
      end
    end
    n_tests++; if (xfer_cnt !== 16'd3) begin n_fail++; $display("FAIL lat_xfer: got %0d expected 3", xfer_cnt); end
  endtask

  task automatic test_backpressure();
    int reads;
    do_reset();
    for (int i = 0; i < 8; i++) push_word(word_t'($urandom));
    reads = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      reads += int'(s_rd);
      if (i >= 2) begin
        n_tests++; if (s_valid !== 1'b1 || s_data !== words_q[0]) begin n_fail++; $display("FAIL bp_hold cyc%0d: got v=%b d=%h expected v=1 d=%h", i, s_valid, s_data, words_q[0]); end
      end
    end
    n_tests++; if (reads != 2) begin n_fail++; $display("FAIL bp_reads: got %0d expected 2", reads); end
    m_ready = 1'b1;
    for (int k = 0; k < 40 && got_q.size() < 8; k++) cycle();
    n_tests++; if (got_q.size() != 8) begin n_fail++; $display("FAIL bp_count: got %0d expected 8", got_q.size()); end
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      n_tests++; if (got_q[i] !== words_q[i]) begin n_fail++; $display("FAIL bp_data[%0d]: got %h expected %h", i, got_q[i], words_q[i]); end
    end
    n_tests++; if (xfer_cnt !== 16'd8) begin n_fail++; $display("FAIL bp_xfer: got %0d expected 8", xfer_cnt); end
  endtask

  task automatic test_flush();
    do_reset();
    push_word(word_t'($urandom)); push_word(word_t'($urandom));
    m_ready = 1'b1;
    for (int k = 0; k < 20 && got_q.size() < 2; k++) cycle();
    m_ready = 1'b0;
    cycle(); cycle();
    clear_logs();
    for (int i = 0; i < 8; i++) push_word(word_t'($urandom));
    cycle(); cycle();           // two reads issued: one word buffered, one in flight
    flush = 1'b1;
    cycle();
    n_tests++; if (s_rd !== 1'b0) begin n_fail++; $display("FAIL flush_rd: got %b expected 0", s_rd); end
    flush = 1'b0;
    cycle();
    n_tests++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b expected 0", s_valid); end
    n_tests++; if (s_rd !== 1'b1) begin n_fail++; $display("FAIL flush_resume: got %b expected 1", s_rd); end
    n_tests++; if (xfer_cnt !== 16'd2) begin n_fail++; $display("FAIL flush_xfer: got %0d expected 2", xfer_cnt); end
    m_ready = 1'b1;
    for (int k = 0; k < 40 && got_q.size() < 6; k++) cycle();
    cycle(); cycle();
    n_tests++; if (got_q.size() != 6) begin n_fail++; $display("FAIL flush_count: got %0d expected 6", got_q.size()); end
    for (int i = 0; i < 6 && i < got_q.size(); i++) begin
      n_tests++; if (got_q[i] !== words_q[i+2]) begin n_fail++; $display("FAIL flush_data[%0d]: got %h expected %h", i, got_q[i], words_q[i+2]); end
    end
    n_tests++; if (xfer_cnt !== 16'd8) begin n_fail++; $display("FAIL flush_xfer_end: got %0d expected 8", xfer_cnt); end
  endtask

  task automatic test_toggle();
    do_reset();
    for (int i = 0; i < 20; i++) push_word(word_t'($urandom));
    for (int k = 0; k < 200 && got_q.size() < 20; k++) begin
      m_ready = (k % 2 == 0);
      cycle();
    end
    n_tests++; if (got_q.size() != 20) begin n_fail++; $display("FAIL tog_count: got %0d expected 20", got_q.size()); end
    for (int i = 0; i < 20 && i < got_q.size(); i++) begin
      n_tests++; if (got_q[i] !== words_q[i]) begin n_fail++; $display("FAIL tog_data[%0d]: got %h expected %h", i, got_q[i], words_q[i]); end
    end
    n_tests++; if (xfer_cnt !== 16'd20) begin n_fail++; $display("FAIL tog_xfer: got %0d expected 20", xfer_cnt); end
  endtask

  task automatic test_random();
    logic  hold;
    word_t hold_data;
    do_reset();
    hold = 1'b0; hold_data = '0;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 2) != 0) push_word(word_t'($urandom));
      m_ready = 1'($urandom_range(0, 1));
      flush = ($urandom_range(0, 39) == 0);
      cycle();
      n_tests++; if (pending_q.size() > 2) begin n_fail++; $display("FAIL rnd_outstanding cyc%0d: got %0d expected <=2", k, pending_q.size()); end
      n_tests++; if (s_rd && s_empty) begin n_fail++; $display("FAIL rnd_rd_empty cyc%0d: got rd=1 expected 0", k); end
      if (hold) begin
        n_tests++; if (s_valid !== 1'b1 || s_data !== hold_data) begin n_fail++; $display("FAIL rnd_stable cyc%0d: got v=%b d=%h expected v=1 d=%h", k, s_valid, s_data, hold_data); end
      end
      hold = s_valid && !m_ready && !flush;
      hold_data = s_data;
    end
    flush = 1'b0; m_ready = 1'b1;
    for (int k = 0; k < 400 && (mem_q.size() > 0 || pending_q.size() > 0); k++) cycle();
    cycle(); cycle();
    n_tests++; if (got_q.size() != exp_q.size() || got_q.size() == 0) begin n_fail++; $display("FAIL rnd_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_tests++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rnd_data[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    n_tests++; if (xfer_cnt !== CW'(model_xfer)) begin n_fail++; $display("FAIL rnd_xfer: got %0d expected %0d", xfer_cnt, model_xfer); end
  endtask

`ifdef FIFO_RD_LAST_EN
  task automatic test_last();
    logic exp_post[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 9; i++) push_word(word_t'($urandom));
    m_ready = 1'b1;
    for (int k = 0; k < 40 && got_q.size() < 9; k++) cycle();
    n_tests++; if (got_last_q.size() != 9) begin n_fail++; $display("FAIL last_count: got %0d expected 9", got_last_q.size()); end
    for (int i = 0; i < 9 && i < got_last_q.size(); i++) begin
      n_tests++; if (got_last_q[i] !== (i == 3 || i == 7)) begin n_fail++; $display("FAIL last_beat[%0d]: got %b expected %b", i, got_last_q[i], (i == 3 || i == 7)); end
    end
    for (int i = 0; i < 10; i++) push_word(word_t'($urandom));
    for (int k = 0; k < 40 && got_q.size() < 11; k++) cycle();
    m_ready = 1'b0;
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    m_ready = 1'b1;
    for (int k = 0; k < 40 && got_q.size() < 15; k++) cycle();
    n_tests++; if (got_last_q.size() < 15) begin n_fail++; $display("FAIL last_post_count: got %0d expected >=15", got_last_q.size()); end
    for (int i = 9; i < 11 && i < got_last_q.size(); i++) begin
      n_tests++; if (got_last_q[i] !== 1'b0) begin n_fail++; $display("FAIL last_pre[%0d]: got %b expected 0", i, got_last_q[i]); end
    end
    for (int i = 0; i < 4 && i + 11 < got_last_q.size(); i++) begin
      n_tests++; if (got_last_q[i+11] !== exp_post[i]) begin n_fail++; $display("FAIL last_post[%0d]: got %b expected %b", i, got_last_q[i+11], exp_post[i]); end
    end
    m_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_latency();
    test_backpressure();
    test_flush();
    test_toggle();
    test_random();
`ifdef FIFO_RD_LAST_EN
    test_last();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
